m_fetch_queue: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the decode/immediate-generation stage and drives the instruction memory address.
- Owns the fetch PC and reads the asynchronous instruction memory, which returns an instruction in the same cycle as its address.
- Buffers each fetched instruction, together with its PC, in a small circular queue.
- Hands entries to decode over a valid/ready handshake, which lets decode stall.
- Accepts a redirect (branch/jump target) that flushes the queue and restarts fetch.

---
 rtl/m_fetch_queue_if.sv | 41 ++++
 rtl/m_fetch_queue.sv | 75 +++++++
 tb/tb_m_fetch_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/m_fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory, redirect source and decode.
// The master modport is the fetch queue side; the slave modport is the environment side.
interface m_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   w_imem_adr;
    logic [31:0]   w_imem_insn;
    logic          w_redirect;
    logic [31:0]   w_redirect_pc;
    logic          w_dq_valid;
    logic          w_dq_ready;
    logic [31:0]   w_dq_insn;
    logic [31:0]   w_dq_pc;
    logic [CW-1:0] w_count;

    modport master (
        output w_imem_adr,
        input  w_imem_insn,
        input  w_redirect,
        input  w_redirect_pc,
        output w_dq_valid,
        input  w_dq_ready,
        output w_dq_insn,
        output w_dq_pc,
        output w_count
    );

    modport slave (
        input  w_imem_adr,
        output w_imem_insn,
        output w_redirect,
        output w_redirect_pc,
        input  w_dq_valid,
        output w_dq_ready,
        input  w_dq_insn,
        input  w_dq_pc,
        input  w_count
    );
endinterface

// File: rtl/m_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads async imem and queues {insn, pc}
// in a circular buffer handed to decode over valid/ready; redirect flushes and restarts.
module m_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic             w_clk,
    input logic             w_rst,
    m_fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_fpc;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mem_insn [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];

    logic          w_not_full;
    logic          w_pop;
    logic          w_push;
    logic          w_unused_pc_lsb;

    assign w_not_full = (r_count < CW'(DEPTH));
    assign w_pop      = (r_count != '0) && bus.w_dq_ready;
    // A full queue may still fetch when the head leaves in the same cycle.
    assign w_push     = !w_rst && !bus.w_redirect && (w_not_full || w_pop);

    // Redirect targets are word aligned; the low bits are dropped on purpose.
    assign w_unused_pc_lsb = ^bus.w_redirect_pc[1:0];

    // Control state: fetch PC, pointers and occupancy.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_fpc   <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.w_redirect) begin
            r_fpc   <= {bus.w_redirect_pc[31:2], 2'b00};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
                r_fpc  <= r_fpc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage is never reset; contents are ignored while invalid.
    always_ff @(posedge w_clk) begin
        if (w_push) begin
            r_mem_insn[r_tail] <= bus.w_imem_insn;
            r_mem_pc[r_tail]   <= r_fpc;
        end
    end

    assign bus.w_imem_adr = r_fpc;
    assign bus.w_dq_valid = (r_count != '0);
    assign bus.w_dq_insn  = r_mem_insn[r_head];
    assign bus.w_dq_pc    = r_mem_pc[r_head];
    assign bus.w_count    = r_count;
endmodule

// File: tb/tb_m_fetch_queue.sv
// Self-checking bench for m_fetch_queue: a vector table plus a queue scoreboard that
// tracks every fetched {pc, insn} from push to pop against an imem of word k = 0x100+k.
module tb_m_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        int          ec;
        logic [31:0] eadr;
        logic        hchk;
        logic [31:0] epc;
        logic [31:0] einsn;
    } vec_t;

    logic clk;
    logic rst;

    m_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    m_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .w_clk (clk),
        .w_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    assign bus.w_imem_insn = imem(bus.w_imem_adr);

    ent_t        sb[$];
    logic [31:0] m_fpc;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, advance the reference model, then compare after the edge.
    task automatic step(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        bit pop;
        bit push;
        @(negedge clk);
        rst               = r;
        bus.w_dq_ready    = rdy;
        bus.w_redirect    = rd;
        bus.w_redirect_pc = rpc;
        if (r) begin
            sb.delete();
            m_fpc = RESET_PC;
        end else if (rd) begin
            sb.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            pop  = (sb.size() != 0) && rdy;
            push = (sb.size() < DEPTH) || pop;
            if (pop) void'(sb.pop_front());
            if (push) begin
                sb.push_back('{pc: m_fpc, insn: imem(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        chk("sb_valid", 32'(bus.w_dq_valid), 32'(sb.size() != 0));
        chk("sb_count", 32'(bus.w_count), 32'(sb.size()));
        chk("sb_adr", bus.w_imem_adr, m_fpc);
        if (sb.size() != 0) begin
            chk("sb_head_pc", bus.w_dq_pc, sb[0].pc);
            chk("sb_head_insn", bus.w_dq_insn, sb[0].insn);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic ev, input int ec, input logic [31:0] eadr,
                                input logic hchk, input logic [31:0] epc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.redir = rd; v.rpc = rpc;
        v.ev = ev; v.ec = ec; v.eadr = eadr; v.hchk = hchk;
        v.epc = epc; v.einsn = 32'h100 + (epc >> 2);
        return v;
    endfunction

    initial begin
        rst               = 1'b1;
        bus.w_dq_ready    = 1'b0;
        bus.w_redirect    = 1'b0;
        bus.w_redirect_pc = '0;
        m_fpc             = RESET_PC;

        // Reset, stall until full, drain while full, redirect, refill, reset again.
        tbl[0]  = mk(1, 0, 0, 0,     0, 0, 32'h00, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,     1, 1, 32'h04, 1, 32'h00);
        tbl[2]  = mk(0, 0, 0, 0,     1, 2, 32'h08, 1, 32'h00);
        tbl[3]  = mk(0, 0, 0, 0,     1, 3, 32'h0C, 1, 32'h00);
        tbl[4]  = mk(0, 0, 0, 0,     1, 4, 32'h10, 1, 32'h00);
        tbl[5]  = mk(0, 0, 0, 0,     1, 4, 32'h10, 1, 32'h00);
        tbl[6]  = mk(0, 0, 0, 0,     1, 4, 32'h10, 1, 32'h00);
        tbl[7]  = mk(0, 1, 0, 0,     1, 4, 32'h14, 1, 32'h04);
        tbl[8]  = mk(0, 1, 0, 0,     1, 4, 32'h18, 1, 32'h08);
        tbl[9]  = mk(0, 1, 0, 0,     1, 4, 32'h1C, 1, 32'h0C);
        tbl[10] = mk(0, 1, 1, 32'h43, 0, 0, 32'h40, 0, 0);
        tbl[11] = mk(0, 1, 0, 0,     1, 1, 32'h44, 1, 32'h40);
        tbl[12] = mk(0, 1, 0, 0,     1, 1, 32'h48, 1, 32'h44);
        tbl[13] = mk(0, 0, 0, 0,     1, 2, 32'h4C, 1, 32'h44);
        tbl[14] = mk(0, 0, 0, 0,     1, 3, 32'h50, 1, 32'h44);
        tbl[15] = mk(1, 1, 0, 0,     0, 0, 32'h00, 0, 0);
        tbl[16] = mk(0, 1, 0, 0,     1, 1, 32'h04, 1, 32'h00);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.w_dq_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), 32'(bus.w_count), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d_adr", i), bus.w_imem_adr, tbl[i].eadr);
            if (tbl[i].hchk) begin
                chk($sformatf("tbl%0d_pc", i), bus.w_dq_pc, tbl[i].epc);
                chk($sformatf("tbl%0d_insn", i), bus.w_dq_insn, tbl[i].einsn);
            end
        end

        // Continuous streaming from reset: one entry per cycle, occupancy stays at one.
        step(1, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 0);
            chk("stream_count", 32'(bus.w_count), 32'd1);
            chk("stream_pc", bus.w_dq_pc, 32'(4 * k));
            chk("stream_insn", bus.w_dq_insn, 32'h100 + 32'(k));
        end

        // Redirect while full with decode ready: flushed, no push in that cycle.
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
        chk("full_count", 32'(bus.w_count), 32'd4);
        step(0, 1, 1, 32'h200);
        chk("redir_full_count", 32'(bus.w_count), 32'd0);
        chk("redir_full_valid", 32'(bus.w_dq_valid), 32'd0);
        chk("redir_full_adr", bus.w_imem_adr, 32'h200);
        step(0, 1, 0, 0);
        chk("redir_full_pc", bus.w_dq_pc, 32'h200);
        chk("redir_full_insn", bus.w_dq_insn, 32'h180);

        // Two queued entries, redirect to an unaligned target.
        step(0, 0, 0, 0);
        chk("two_queued", 32'(bus.w_count), 32'd2);
        step(0, 1, 1, 32'h43);
        chk("redir_count", 32'(bus.w_count), 32'd0);
        chk("redir_adr", bus.w_imem_adr, 32'h40);
        step(0, 1, 0, 0);
        chk("redir_pc", bus.w_dq_pc, 32'h40);
        chk("redir_insn", bus.w_dq_insn, 32'h110);

        // Mid-operation reset with three entries and fetch PC 0x20.
        step(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_rst_count", 32'(bus.w_count), 32'd3);
        chk("pre_rst_adr", bus.w_imem_adr, 32'h20);
        step(1, 0, 0, 0);
        chk("rst_count", 32'(bus.w_count), 32'd0);
        chk("rst_valid", 32'(bus.w_dq_valid), 32'd0);
        chk("rst_adr", bus.w_imem_adr, RESET_PC);
        step(0, 1, 0, 0);
        chk("rst_resume_pc", bus.w_dq_pc, RESET_PC);
        chk("rst_resume_insn", bus.w_dq_insn, 32'h100);

        // Fetch PC wraps past the top of the address space.
        step(0, 1, 1, 32'hFFFF_FFF9);
        chk("wrap_adr0", bus.w_imem_adr, 32'hFFFF_FFF8);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("wrap_adr", bus.w_imem_adr, 32'h0);
        chk("wrap_pc", bus.w_dq_pc, 32'hFFFF_FFFC);

        // Random ready, occasional redirect and reset, all tracked by the scoreboard.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
